// File: rtl/blockram_banked_if.sv
// Read/write handshake bundle for blockram_banked: one read port, one write port.
interface blockram_banked_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic                    rd_req;
    logic                    rd_ready;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    rd_valid;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    wr_req;
    logic                    wr_ready;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] wr_be;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
        input  rd_ready, rd_valid, rd_data, wr_ready
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
        output rd_ready, rd_valid, rd_data, wr_ready
    );
endinterface

// File: rtl/blockram_banked.sv
// Banked simple-dual-port block RAM with byte enables, write-first forwarding and a clear sweep.
// Define BLOCKRAM_BANKED_OUTREG_EN for an extra output register (read latency 2 instead of 1).
module blockram_banked #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    BANK_BITS   = 2,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    output logic            busy,
    blockram_banked_if.slave bus
);
    localparam int BE_W       = DATA_WIDTH / 8;
    localparam int NBANKS     = 1 << BANK_BITS;
    localparam int LOW_W      = ADDR_WIDTH - BANK_BITS;
    localparam int BANK_DEPTH = 1 << LOW_W;
    localparam int BSEL_W     = (BANK_BITS > 0) ? BANK_BITS : 1;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    rd_acc, wr_acc;
    logic                    we_en;
    logic [ADDR_WIDTH-1:0]   we_addr;
    logic [DATA_WIDTH-1:0]   we_data;
    logic [BE_W-1:0]         we_be;
    logic [DATA_WIDTH-1:0]   ram_bus [NBANKS];
    logic [DATA_WIDTH-1:0]   ram_sel;
    logic [BSEL_W-1:0]       bsel_p0;
    logic [BE_W-1:0]         fwd_be_p0;
    logic [DATA_WIDTH-1:0]   fwd_data_p0;
    logic                    vld_p0;
    logic                    seen_p0;
    logic [DATA_WIDTH-1:0]   rd_data_p0;

    function automatic logic [BSEL_W-1:0] bank_of(input logic [ADDR_WIDTH-1:0] a);
        return BSEL_W'(a >> LOW_W);
    endfunction

    function automatic logic [LOW_W-1:0] local_of(input logic [ADDR_WIDTH-1:0] a);
        return a[LOW_W-1:0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [BE_W-1:0]       be
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        busy         = 1'b0;
        bus.rd_ready = 1'b0;
        bus.wr_ready = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                busy  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = ST_RUN;
            end
            ST_RUN: begin
                bus.rd_ready = 1'b1;
                bus.wr_ready = 1'b1;
                if (clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    assign rd_acc = bus.rd_req & bus.rd_ready;
    assign wr_acc = bus.wr_req & bus.wr_ready;

    // The sweep owns the write port while clearing; user writes are not accepted then.
    always_comb begin
        we_en   = wr_acc;
        we_addr = bus.wr_addr;
        we_data = bus.wr_data;
        we_be   = bus.wr_be;
        if (state_q == ST_CLEAR) begin
            we_en   = 1'b1;
            we_addr = cnt_q;
            we_data = CLEAR_VALUE;
            we_be   = '1;
        end
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
        logic [DATA_WIDTH-1:0] ram_q;

        always_ff @(posedge clk) begin
            if (we_en && bank_of(we_addr) == BSEL_W'(b)) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (we_be[i]) mem[local_of(we_addr)][8*i +: 8] <= we_data[8*i +: 8];
                end
            end
            if (rd_acc) ram_q <= mem[local_of(bus.rd_addr)];
        end

        assign ram_bus[b] = ram_q;
    end

    // Stage p0: RAM output, bank select and same-address write bytes captured together.
    always_ff @(posedge clk) begin
        if (rd_acc) begin
            bsel_p0     <= bank_of(bus.rd_addr);
            fwd_be_p0   <= (wr_acc && bus.wr_addr == bus.rd_addr) ? bus.wr_be : '0;
            fwd_data_p0 <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            seen_p0 <= 1'b0;
        end else begin
            vld_p0 <= rd_acc;
            if (rd_acc) seen_p0 <= 1'b1;
        end
    end

    if (BANK_BITS == 0) begin : g_sel_one
        assign ram_sel = ram_bus[0];
    end else begin : g_sel_mux
        assign ram_sel = ram_bus[bsel_p0];
    end

    // Output reads as zero until the first read lands, so the data registers need no reset.
    assign rd_data_p0 = seen_p0 ? merge_bytes(ram_sel, fwd_data_p0, fwd_be_p0) : '0;

`ifdef BLOCKRAM_BANKED_OUTREG_EN
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] rd_data_p1;

    // Stage p1: optional output register after the bank mux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            rd_data_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) rd_data_p1 <= rd_data_p0;
        end
    end

    assign bus.rd_valid = vld_p1;
    assign bus.rd_data  = rd_data_p1;
`else
    assign bus.rd_valid = vld_p0;
    assign bus.rd_data  = rd_data_p0;
`endif

endmodule

// File: tb/tb_blockram_banked.sv
// Self-checking bench for blockram_banked: directed steps plus random traffic against a word-array model.
module tb_blockram_banked;
    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int BB    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int BEW   = DW / 8;
    localparam logic [DW-1:0] CV = '0;
`ifdef BLOCKRAM_BANKED_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    logic clear;
    logic busy;

    blockram_banked_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    blockram_banked #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BANK_BITS  (BB),
        .CLEAR_VALUE(CV)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .busy (busy),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem_m [DEPTH];
    bit            m_run;
    int            m_left;
    logic [DW:0]   pipe_q [$];
    logic [DW-1:0] last_d;
    int            n_chk;
    int            n_fail;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [BEW-1:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int i = 0; i < BEW; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic model_fill();
        foreach (mem_m[i]) mem_m[i] = CV;
    endtask

    // One clock cycle: drive inputs, advance the model, then check outputs after the edge.
    task automatic cyc(input logic rr, input logic [AW-1:0] ra, input logic wr,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [BEW-1:0] be, input logic clr);
        logic          acc_r, acc_w;
        logic [DW-1:0] d;
        logic [DW:0]   e;
        bus.rd_req  = rr;
        bus.rd_addr = ra;
        bus.wr_req  = wr;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.wr_be   = be;
        clear       = clr;
        acc_r = rr && m_run;
        acc_w = wr && m_run;
        if (acc_r) begin
            d = mem_m[ra];
            if (acc_w && wa == ra) d = merge(d, wd, be);
            pipe_q.push_back({1'b1, d});
        end else begin
            pipe_q.push_back({1'b0, {DW{1'b0}}});
        end
        if (acc_w) mem_m[wa] = merge(mem_m[wa], wd, be);
        if (m_run) begin
            if (clr) begin
                m_run  = 1'b0;
                m_left = DEPTH;
                model_fill();
            end
        end else begin
            m_left--;
            if (m_left == 0) m_run = 1'b1;
        end
        @(posedge clk);
        #1;
        check("busy", DW'(busy), DW'(!m_run));
        check("rd_ready", DW'(bus.rd_ready), DW'(m_run));
        check("wr_ready", DW'(bus.wr_ready), DW'(m_run));
        if (pipe_q.size() >= LAT) begin
            e = pipe_q.pop_front();
            check("rd_valid", DW'(bus.rd_valid), DW'(e[DW]));
            if (e[DW]) last_d = e[DW-1:0];
        end else begin
            check("rd_valid_fill", DW'(bus.rd_valid), '0);
        end
        check("rd_data", bus.rd_data, last_d);
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        cyc(1'b1, a, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic wrt(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BEW-1:0] be);
        cyc(1'b0, '0, 1'b1, a, d, be, 1'b0);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        clear       = 1'b0;
        bus.rd_req  = 1'b0;
        bus.rd_addr = '0;
        bus.wr_req  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.wr_be   = '0;
        #2;
        check("rst_busy", DW'(busy), DW'(1));
        check("rst_rd_valid", DW'(bus.rd_valid), '0);
        check("rst_rd_data", bus.rd_data, '0);
        check("rst_rd_ready", DW'(bus.rd_ready), '0);
        check("rst_wr_ready", DW'(bus.wr_ready), '0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_run  = 1'b0;
        m_left = DEPTH;
        model_fill();
        pipe_q.delete();
        last_d = '0;
    endtask

    task automatic wait_sweep(input int expect_len);
        int n;
        n = 0;
        while (busy === 1'b1 && n < DEPTH + 100) begin
            idle();
            n++;
        end
        check("sweep_len", DW'(n), DW'(expect_len));
    endtask

    task automatic flush();
        for (int i = 0; i < LAT + 1; i++) idle();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        #3;
        do_reset();
        wait_sweep(DEPTH);

        rd(12'h000);
        rd(12'd1234);
        rd(12'hFFF);
        flush();

        wrt(12'h0A5, 32'hDEADBEEF, 4'b1111);
        wrt(12'h0A5, 32'h11223344, 4'b0101);
        rd(12'h0A5);
        flush();

        cyc(1'b1, 12'h800, 1'b1, 12'h800, 32'hCAFEF00D, 4'b0011, 1'b0);
        rd(12'hC00);
        rd(12'h800);
        flush();

        wrt(12'h3F0, 32'h12345678, 4'b0000);
        rd(12'h3F0);
        flush();

        for (int i = 0; i < 16; i++) rd(AW'(i));
        flush();

        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] ra, wa;
            ra = AW'(($urandom_range(0, 3) << (AW - 2)) | $urandom_range(0, 3));
            wa = AW'(($urandom_range(0, 3) << (AW - 2)) | $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) wa = ra;
            cyc(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa,
                DW'($urandom), BEW'($urandom), 1'b0);
        end
        flush();

        cyc(1'b1, 12'h0A5, 1'b0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 12'h005, 1'b1, 12'h005, 32'hFFFFFFFF, 4'b1111, 1'b1);
        wait_sweep(DEPTH - 3);
        rd(12'h0A5);
        rd(12'h005);
        flush();

        cyc(1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 100; i++) idle();
        do_reset();
        wait_sweep(DEPTH);

        for (int i = 0; i < 100; i++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, 7) << (AW - 3));
            cyc(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), a,
                DW'($urandom), BEW'($urandom), 1'b0);
        end
        flush();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
